// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - opcodes, state encoding and helper constants for alu_exec
package alu_exec_pkg;

  localparam logic [2:0] OC_ADD = 3'b000;
  localparam logic [2:0] OC_SUB = 3'b001;
  localparam logic [2:0] OC_MUL = 3'b010;
  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;
  localparam logic [2:0] OC_XOR = 3'b101;
  localparam logic [2:0] OC_OR  = 3'b110;
  localparam logic [2:0] OC_AND = 3'b111;

  localparam logic [2:0] OC_UNARY = OC_NOT;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_FETCH_A = 3'd1;
  localparam logic [2:0] ENC_FETCH_B = 3'd2;
  localparam logic [2:0] ENC_LOAD_B  = 3'd3;
  localparam logic [2:0] ENC_EXEC    = 3'd4;
  localparam logic [2:0] ENC_WB      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_FETCH_A = ENC_FETCH_A,
    ST_FETCH_B = ENC_FETCH_B,
    ST_LOAD_B  = ENC_LOAD_B,
    ST_EXEC    = ENC_EXEC,
    ST_WB      = ENC_WB
  } state_t;

endpackage

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - operand sequencer: fetch operands, drive external ALU, write back result
// Optional divide-by-zero guard enabled by defining ALU_EXEC_DIV_GUARD_EN.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            oc,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [ADDR_WIDTH-1:0] src2_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f
);

`ifdef ALU_EXEC_DIV_GUARD_EN
  localparam bit DIV_GUARD_EN = 1'b1;
`else
  localparam bit DIV_GUARD_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [2:0]            oc_q, oc_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] s1_q, s1_d;
  logic [ADDR_WIDTH-1:0] s2_q, s2_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] f_q, f_d;
  logic                  div_err_q, div_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      oc_q      <= '0;
      dst_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      oc_q      <= oc_d;
      dst_q     <= dst_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f_q       <= f_d;
      div_err_q <= div_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    oc_d      = oc_q;
    dst_d     = dst_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    div_err_d = div_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          oc_d    = oc;
          dst_d   = dst_addr;
          s1_d    = src1_addr;
          s2_d    = src2_addr;
          state_d = ST_FETCH_A;
        end
      end
      ST_FETCH_A: state_d = ST_FETCH_B;
      ST_FETCH_B: begin
        a_d = mem_data_in;
        if (oc_q == OC_UNARY) begin
          b_d     = '0;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        b_d     = mem_data_in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        f_d       = alu_f;
        div_err_d = DIV_GUARD_EN && (oc_q == OC_DIV) && (b_q == '0);
        state_d   = ST_WB;
      end
      ST_WB: begin
        div_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Unary ops keep s1 on the bus in FETCH_B so the unused source is never addressed.
  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      ST_FETCH_A: mem_addr = s1_q;
      ST_FETCH_B: mem_addr = (oc_q == OC_UNARY) ? s1_q : s2_q;
      ST_LOAD_B:  mem_addr = s2_q;
      ST_WB:      mem_addr = dst_q;
      default:    mem_addr = '0;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_WB);
  assign mem_we       = (state_q == ST_WB) && !div_err_q;
  assign err          = (state_q == ST_WB) && div_err_q;
  assign mem_data_out = f_q;
  assign alu_oc       = oc_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - randomized self-checking bench for alu_exec with memory and ALU models
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  oc;
  logic [5:0]  dst_addr, src1_addr, src2_addr;
  logic        busy, done, err, mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data_out, mem_data_in, alu_a, alu_b, alu_f;
  logic [2:0]  alu_oc;

  logic [15:0] mem [64];
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef ALU_EXEC_DIV_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_exec #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .oc(oc),
    .dst_addr(dst_addr), .src1_addr(src1_addr), .src2_addr(src2_addr),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
  );

  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a * b;
      3'b011: return (b == 16'd0) ? 16'hFFFF : a / b;
      3'b100: return ~a;
      3'b101: return a ^ b;
      3'b110: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_f = alu_model(alu_oc, alu_a, alu_b);

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data_out;
    mem_data_in <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [5:0] s1, input logic [5:0] s2,
                        input logic [5:0] d, input bit pulse_mid);
    logic [15:0] a, b, exp_f, old_d;
    bit          unary, exp_err, saw_s2;
    int          lat, done_at, busy_cnt, dones;
    unary    = (op == 3'b100);
    a        = mem[s1];
    b        = unary ? 16'd0 : mem[s2];
    old_d    = mem[d];
    exp_f    = alu_model(op, a, b);
    exp_err  = GUARD && (op == 3'b011) && (b == 16'd0);
    lat      = unary ? 4 : 5;
    done_at  = -1;
    busy_cnt = 0;
    dones    = 0;
    saw_s2   = 1'b0;
    @(negedge clk);
    start = 1'b1; oc = op; src1_addr = s1; src2_addr = s2; dst_addr = d;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= lat + 3; cyc++) begin
      @(negedge clk);
      start = pulse_mid && (cyc == 2);
      busy_cnt += int'(busy);
      if (busy && mem_addr == s2) saw_s2 = 1'b1;
      if (done) begin
        dones++;
        done_at = cyc;
        check("wb_we", mem_we, !exp_err);
        check("wb_err", err, exp_err);
        check("wb_addr", mem_addr, d);
        if (!exp_err) check("wb_data", mem_data_out, exp_f);
      end
    end
    start = 1'b0;
    check("done_count", dones, 1);
    check("done_latency", done_at, lat);
    check("busy_cycles", busy_cnt, lat);
    check("mem_dst", mem[d], exp_err ? old_d : exp_f);
    if (unary && s2 != s1 && s2 != d) check("unary_no_src2", saw_s2, 0);
  endtask

  initial begin
    int done_pos[$];
    int dcnt;
    logic [15:0] keep;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    rst = 1'b1; start = 1'b0; oc = '0; dst_addr = '0; src1_addr = '0; src2_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dout", mem_data_out, 0);
    check("rst_alu", {alu_oc, alu_a, alu_b} == '0, 1);
    rst = 1'b0;

    mem[1] = 16'd7; mem[2] = 16'd5;
    run_op(3'b000, 6'd1, 6'd2, 6'd3, 1'b0);
    check("add_result", mem[3], 16'd12);
    mem[4] = 16'h00FF;
    run_op(3'b100, 6'd4, 6'd2, 6'd5, 1'b0);
    check("not_result", mem[5], 16'hFF00);
    mem[1] = 16'd9; mem[2] = 16'd0;
    run_op(3'b011, 6'd1, 6'd2, 6'd6, 1'b0);
    mem[1] = 16'd3; mem[2] = 16'd5;
    run_op(3'b001, 6'd1, 6'd2, 6'd1, 1'b0);
    check("sub_wrap", mem[1], 16'hFFFE);
    run_op(3'b110, 6'd7, 6'd8, 6'd9, 1'b1);

    // start held high: back-to-back operations every 6 cycles
    @(negedge clk);
    start = 1'b1; oc = 3'b101; src1_addr = 6'd10; src2_addr = 6'd11; dst_addr = 6'd12;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) done_pos.push_back(cyc);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_done_count", done_pos.size(), 3);
    if (done_pos.size() == 3) begin
      check("held_spacing1", done_pos[1] - done_pos[0], 6);
      check("held_spacing2", done_pos[2] - done_pos[1], 6);
    end

    // reset while in LOAD_B
    keep = mem[20];
    @(negedge clk);
    start = 1'b1; oc = 3'b000; src1_addr = 6'd21; src2_addr = 6'd22; dst_addr = 6'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_outs", {done, err, mem_we, mem_addr, mem_data_out, alu_oc, alu_a, alu_b} == '0, 1);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      dcnt += int'(done) + int'(mem_we) + int'(busy);
    end
    check("rst_mid_quiet", dcnt, 0);
    check("rst_mid_dst", mem[20], keep);

    for (int k = 0; k < 25; k++) begin
      logic [5:0] r1, r2, rd;
      r1 = 6'($urandom); r2 = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? r1 : 6'($urandom);
      if ($urandom_range(0, 4) == 0) mem[r2] = 16'd0;
      run_op(3'($urandom), r1, r2, rd, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
